div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 17 +
 rtl/div_seq_clz.sv | 19 +
 rtl/div_seq.sv | 167 ++++++++++++++++
 tb/tb_div_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and
// handshake constants used by div_seq.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_clz.sv
// Combinational leading-zero count; an all-zero input yields WIDTH.
module div_seq_clz #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       value,
  output logic [$clog2(WIDTH):0] lz
);

  localparam int CW = $clog2(WIDTH) + 1;

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      lz = value[i] ? CW'(WIDTH - 1 - i) : lz;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider with signed/unsigned modes, abort and
// divide-by-zero handling. Define DIV_SEQ_EARLY_TERM_EN to skip leading zeros.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dbz_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [2*WIDTH-1:0] RES_ZERO = {(2*WIDTH){1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  div_state_e       state_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvs_r;
  logic             neg_quo_r;
  logic             neg_rem_r;
  logic             dbz_r;
  logic [CNT_W-1:0] cnt_r;

  logic             sign1_s;
  logic             sign2_s;
  logic [WIDTH-1:0] mag1_s;
  logic [WIDTH-1:0] mag2_s;
  logic [WIDTH-1:0] quo_load_s;
  logic [CNT_W-1:0] cnt_load_s;
  logic [WIDTH:0]   partial_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] quo_step_s;
  logic [WIDTH-1:0] rem_step_s;

  assign sign1_s = signed_div_i & opdata1_i[WIDTH-1];
  assign sign2_s = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1_s  = sign1_s ? negate(opdata1_i) : opdata1_i;
  assign mag2_s  = sign2_s ? negate(opdata2_i) : opdata2_i;

`ifdef DIV_SEQ_EARLY_TERM_EN
  logic [CNT_W-1:0] lz_s;

  div_seq_clz #(.WIDTH(WIDTH)) u_clz (
    .value (mag1_s),
    .lz    (lz_s)
  );

  // Normalise the dividend so only its significant bits are iterated.
  assign quo_load_s = mag1_s << lz_s;
  assign cnt_load_s = (lz_s > CNT_LAST) ? CNT_ZERO : (CNT_LAST - lz_s);
`else
  assign quo_load_s = mag1_s;
  assign cnt_load_s = CNT_LAST;
`endif

  // A WIDTH+1 bit trial subtract: its top bit is the borrow.
  assign partial_s  = {rem_r, quo_r[WIDTH-1]};
  assign trial_s    = partial_s - {1'b0, dvs_r};
  assign rem_step_s = trial_s[WIDTH] ? partial_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
  assign quo_step_s = {quo_r[WIDTH-2:0], ~trial_s[WIDTH]};

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= DivFree;
      quo_r     <= ZERO_W;
      rem_r     <= ZERO_W;
      dvs_r     <= ZERO_W;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dbz_r     <= 1'b0;
      cnt_r     <= CNT_ZERO;
      result_o  <= RES_ZERO;
      ready_o   <= DivResultNotReady;
      busy_o    <= 1'b0;
      dbz_o     <= 1'b0;
    end else begin
      case (state_r)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= RES_ZERO;
          dbz_o    <= 1'b0;
          if (start_i == DivStop || annul_i) begin
            busy_o <= 1'b0;
          end else begin
            busy_o    <= 1'b1;
            dvs_r     <= mag2_s;
            neg_quo_r <= sign1_s ^ sign2_s;
            neg_rem_r <= sign1_s;
            cnt_r     <= cnt_load_s;
            if (opdata2_i == ZERO_W) begin
              state_r <= DivByZero;
              quo_r   <= ONES_W;
              rem_r   <= opdata1_i;
              dbz_r   <= 1'b1;
            end else begin
              state_r <= DivOn;
              quo_r   <= quo_load_s;
              rem_r   <= ZERO_W;
              dbz_r   <= 1'b0;
            end
          end
        end
        DivByZero: begin
          busy_o  <= 1'b0;
          state_r <= annul_i ? DivFree : DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            state_r <= DivFree;
            busy_o  <= 1'b0;
          end else if (cnt_r == CNT_ZERO) begin
            // Last step: apply the sign fix-up on the way into END.
            state_r <= DivEnd;
            busy_o  <= 1'b0;
            quo_r   <= neg_quo_r ? negate(quo_step_s) : quo_step_s;
            rem_r   <= neg_rem_r ? negate(rem_step_s) : rem_step_s;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
            quo_r <= quo_step_s;
            rem_r <= rem_step_s;
          end
        end
        DivEnd: begin
          busy_o <= 1'b0;
          if (annul_i || start_i == DivStop) begin
            state_r  <= DivFree;
            ready_o  <= DivResultNotReady;
            result_o <= RES_ZERO;
            dbz_o    <= 1'b0;
          end else begin
            ready_o  <= DivResultReady;
            result_o <= {rem_r, quo_r};
            dbz_o    <= dbz_r;
          end
        end
        default: begin
          state_r  <= DivFree;
          ready_o  <= DivResultNotReady;
          result_o <= RES_ZERO;
          busy_o   <= 1'b0;
          dbz_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (WIDTH=32); latencies follow
// DIV_SEQ_EARLY_TERM_EN when it is defined.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = 32'd0;
  logic [31:0] opdata2_i = 32'd0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        dbz_o;

  int total = 0;
  int bad   = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .dbz_o        (dbz_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
    int          lat_et;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input int lat, input int lat_et);
`ifdef DIV_SEQ_EARLY_TERM_EN
    return lat_et + (lat - lat);
`else
    return lat + (lat_et - lat_et);
`endif
  endfunction

  // Start an operation, scramble operands after capture, wait for ready.
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output logic dz, output int lat);
    @(negedge clk);
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i    = ~a;
    opdata2_i    = b ^ 32'h5A5A_0F0F;
    signed_div_i = ~sg;
    lat = 0;
    res = 64'd0;
    dz  = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = k;
        res = result_o;
        dz  = dbz_o;
        break;
      end
    end
  endtask

  task automatic release_op(input string name);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_rel_ready"}, {63'd0, ready_o}, 64'd0);
    chk({name, "_rel_result"}, result_o, 64'd0);
  endtask

  logic [63:0] res;
  logic        dz;
  int          lat;
  logic [31:0] ann_a;
  logic [63:0] ann_res;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 1'b0, 33, 8};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33, 4};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 1'b0, 33, 33};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          {32'h0000_0005, 32'hFFFF_FFFF}, 1'b1, 2, 2};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0000_0000, 32'hFFFF_FFFF}, 1'b0, 33, 33};
    vecs[5]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          {32'h0000_0001, 32'h7FFF_FFFC}, 1'b0, 33, 33};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, 33, 4};
    vecs[7]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  {32'hFFFF_FFFF, 32'h0000_0003}, 1'b0, 33, 4};
    vecs[8]  = '{1'b0, 32'd3,          32'd10,         {32'h0000_0003, 32'h0000_0000}, 1'b0, 33, 3};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b1, 2, 2};
    vecs[10] = '{1'b0, 32'd0,          32'd9,          {32'h0000_0000, 32'h0000_0000}, 1'b0, 33, 2};
    vecs[11] = '{1'b0, 32'h1234_5678,  32'h0000_1000,  {32'h0000_0678, 32'h0001_2345}, 1'b0, 33, 30};
    vecs[12] = '{1'b0, 32'd3,          32'd1,          {32'h0000_0000, 32'h0000_0003}, 1'b0, 33, 3};

    // Reset state, asynchronous (no clock edge yet).
    #1;
    chk("reset_result", result_o, 64'd0);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_busy", {63'd0, busy_o}, 64'd0);
    chk("reset_dbz", {63'd0, dbz_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].sg, vecs[i].a, vecs[i].b, res, dz, lat);
      chk($sformatf("v%0d_result", i), res, vecs[i].res);
      chk($sformatf("v%0d_dbz", i), {63'd0, dz}, {63'd0, vecs[i].dz});
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(pick_lat(vecs[i].lat, vecs[i].lat_et)));
      release_op($sformatf("v%0d", i));
    end

    // Divide by zero: busy for exactly one cycle, result held while start stays high.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd5;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    @(posedge clk); #1;
    chk("dz_busy_c1", {63'd0, busy_o}, 64'd1);
    chk("dz_ready_c1", {63'd0, ready_o}, 64'd0);
    @(posedge clk); #1;
    chk("dz_busy_c2", {63'd0, busy_o}, 64'd0);
    chk("dz_ready_c2", {63'd0, ready_o}, 64'd0);
    @(posedge clk); #1;
    chk("dz_ready_c3", {63'd0, ready_o}, 64'd1);
    chk("dz_flag_c3", {63'd0, dbz_o}, 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("dz_hold_ready", {63'd0, ready_o}, 64'd1);
    chk("dz_hold_result", result_o, {32'h0000_0005, 32'hFFFF_FFFF});
    release_op("dz");

    // Annul mid-operation, then restart with start still high.
`ifdef DIV_SEQ_EARLY_TERM_EN
    ann_a = 32'hFFFF_FFF0;
    ann_res = {32'h0000_0002, 32'h2492_4922};
`else
    ann_a = 32'd100;
    ann_res = {32'h0000_0002, 32'h0000_000E};
`endif
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = ann_a;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      chk($sformatf("annul_pre_ready_c%0d", c), {63'd0, ready_o}, 64'd0);
    end
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    chk("annul_busy", {63'd0, busy_o}, 64'd0);
    chk("annul_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    @(posedge clk); #1;
    chk("annul_restart_busy", {63'd0, busy_o}, 64'd1);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = k;
        break;
      end
    end
    chk("annul_restart_latency", 64'(lat), 64'd33);
    chk("annul_restart_result", result_o, ann_res);
    release_op("annul");

    // Asynchronous reset mid-operation.
    @(negedge clk);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2;
    chk("rst_mid_busy_before", {63'd0, busy_o}, 64'd1);
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, res, dz, lat);
    chk("rst_after_result", res, {32'h0000_0002, 32'h0000_000E});
    chk("rst_after_latency", 64'(lat), 64'(pick_lat(33, 8)));

    // Asynchronous reset while a result is being presented.
    #2;
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    chk("rst_end_result", result_o, 64'd0);
    chk("rst_end_ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'd5, 32'd0, res, dz, lat);
    chk("rst_final_dbz", {63'd0, dz}, 64'd1);
    chk("rst_final_result", res, {32'h0000_0005, 32'hFFFF_FFFF});
    release_op("rst_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
